// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: conditions the raw board switches and pushbutton that feed a
// 2:1 mux. All four inputs pass through two-flop synchronizers. The button is
// debounced by a four-state FSM. The mux select toggles on each accepted
// press in manual mode, or every AUTO_PERIOD cycles in auto mode. A wrapping
// press counter is exported for display.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_i,
    input  logic             sw_a_i,
    input  logic             sw_b_i,
    input  logic             auto_en_i,
    output logic             a_o,
    output logic             b_o,
    output logic             s_o,
    output logic             s_toggle_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    // The debounce counter is at least 8 bits wide, and wider only if the
    // debounce length requires it.
    localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 8) ? $clog2(DEBOUNCE_CYCLES) : 8;
    localparam int PW = $clog2(AUTO_PERIOD);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] AP_LAST = PW'(AUTO_PERIOD - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    // Synchronizer stages: *_m_q is the metastability catcher and *_s_q is
    // the stable copy.
    logic btn_m_q, btn_s_q;
    logic a_m_q, a_s_q;
    logic b_m_q, b_s_q;
    logic auto_m_q, auto_s_q;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             press_evt_s;

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             s_q, s_d;
    logic             s_toggle_q, s_toggle_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    // Two-flop synchronizers for all asynchronous board inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            a_m_q    <= 1'b0;
            a_s_q    <= 1'b0;
            b_m_q    <= 1'b0;
            b_s_q    <= 1'b0;
            auto_m_q <= 1'b0;
            auto_s_q <= 1'b0;
        end else begin
            btn_m_q  <= btn_i;
            btn_s_q  <= btn_m_q;
            a_m_q    <= sw_a_i;
            a_s_q    <= a_m_q;
            b_m_q    <= sw_b_i;
            b_s_q    <= b_m_q;
            auto_m_q <= auto_en_i;
            auto_s_q <= auto_m_q;
        end
    end

    // Debounce next-state logic. A press is accepted only after the
    // synchronized button has stayed high long enough. A release is accepted
    // only after it has stayed low long enough.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_CHK: begin
                if (!btn_s_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    press_evt_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                // Holding the button never re-fires the press event.
                if (!btn_s_q) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_REL_CHK: begin
                // A bounce during release returns to PRESSED without a new event.
                if (btn_s_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select generation. Auto mode owns the select exclusively, so a press
    // there only counts and never causes a second toggle. Leaving auto mode
    // clears the period counter and freezes the select.
    always_comb begin
        pcnt_d      = pcnt_q;
        s_d         = s_q;
        press_cnt_d = press_cnt_q;
        if (press_evt_s) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end else begin
            press_cnt_d = press_cnt_q;
        end
        if (auto_s_q) begin
            if (pcnt_q == AP_LAST) begin
                pcnt_d = {PW{1'b0}};
                s_d    = ~s_q;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
                s_d    = s_q;
            end
        end else begin
            pcnt_d = {PW{1'b0}};
            if (press_evt_s) begin
                s_d = ~s_q;
            end else begin
                s_d = s_q;
            end
        end
        s_toggle_d = s_d ^ s_q;
    end

    // Select, toggle pulse, period counter and press counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q      <= {PW{1'b0}};
            s_q         <= 1'b0;
            s_toggle_q  <= 1'b0;
            press_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pcnt_q      <= pcnt_d;
            s_q         <= s_d;
            s_toggle_q  <= s_toggle_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign a_o         = a_s_q;
    assign b_o         = b_s_q;
    assign s_o         = s_q;
    assign s_toggle_o  = s_toggle_q;
    assign press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Testbench for mux_sel_ctrl (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, CNT_W=2).
// A vector table covers reset and switch synchronization. Hand-written
// sequences cover debounce, auto mode, counter wrap and reset mid-debounce.
module tb_mux_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_i;
    logic       sw_a_i;
    logic       sw_b_i;
    logic       auto_en_i;
    logic       a_o;
    logic       b_o;
    logic       s_o;
    logic       s_toggle_o;
    logic [1:0] press_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Expected output state, tracked by the bench.
    logic       exp_a;
    logic       exp_b;
    logic       exp_s;
    logic [1:0] exp_cnt;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic       sw_a;
        logic       sw_b;
        logic       auto_en;
        logic [5:0] exp;   // {a, b, s, s_toggle, press_cnt[1:0]}
    } vec_t;

    vec_t tbl [11];

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (8),
        .CNT_W          (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_i      (btn_i),
        .sw_a_i     (sw_a_i),
        .sw_b_i     (sw_b_i),
        .auto_en_i  (auto_en_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .s_o        (s_o),
        .s_toggle_o (s_toggle_o),
        .press_cnt_o(press_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int n, input logic [5:0] exp);
        logic [5:0] got;
        got = {a_o, b_o, s_o, s_toggle_o, press_cnt_o};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge %0d: got {a,b,s,tog,cnt}=%b required=%b", tag, n, got, exp);
        end
    endtask

    // Compare against the tracked expectations plus the given toggle flag.
    task automatic chk_model(input string tag, input int n, input logic tog);
        chk(tag, n, {exp_a, exp_b, exp_s, tog, exp_cnt});
    endtask

    initial begin
        logic tog;

        // Reset held for three edges with every input at 1, then release.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b00_0_0_00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b00_0_0_00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b00_0_0_00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b00_0_0_00};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b11_0_0_00};
        // Switch patterns: a_o/b_o follow the inputs with two edges of latency.
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b11_0_0_00};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b01_0_0_00};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b00_0_0_00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b10_0_0_00};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b10_0_0_00};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b11_0_0_00};

        rst_n = 1'b0; btn_i = 1'b1; sw_a_i = 1'b1; sw_b_i = 1'b1; auto_en_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            rst_n     = tbl[i].rst_n;
            btn_i     = tbl[i].btn;
            sw_a_i    = tbl[i].sw_a;
            sw_b_i    = tbl[i].sw_b;
            auto_en_i = tbl[i].auto_en;
            tick();
            chk("table", i, tbl[i].exp);
        end

        exp_a = 1'b1; exp_b = 1'b1; exp_s = 1'b0; exp_cnt = 2'd0;

        // Clean press in manual mode: 20 cycles high, then 20 low. The press
        // is accepted at edge 7, and holding the button adds nothing.
        for (int n = 1; n <= 40; n++) begin
            btn_i = (n <= 20);
            tick();
            tog = (n == 7);
            if (tog) begin exp_s = ~exp_s; exp_cnt = exp_cnt + 2'd1; end
            chk_model("clean_press", n, tog);
        end

        // Bounce rejection: high 3, low 2, high 3, low long.
        for (int n = 1; n <= 20; n++) begin
            btn_i = (n <= 3) || (n >= 6 && n <= 8);
            tick();
            chk_model("bounce_reject", n, 1'b0);
        end

        // Release bounce: accepted press, drop 2, rise 2, then low. Only one
        // press is counted.
        for (int n = 1; n <= 34; n++) begin
            btn_i = (n <= 10) || (n == 13) || (n == 14);
            tick();
            tog = (n == 7);
            if (tog) begin exp_s = ~exp_s; exp_cnt = exp_cnt + 2'd1; end
            chk_model("release_bounce", n, tog);
        end

        // Auto mode for 40 cycles. The select toggles at edges 10,18,26,34,42.
        // A press accepted at edge 18 coincides with a toggle: it counts but
        // must not add a second flip. After the mode drops, the select holds.
        for (int n = 1; n <= 60; n++) begin
            auto_en_i = (n <= 40);
            btn_i     = (n >= 12 && n <= 25);
            tick();
            tog = (n == 10) || (n == 18) || (n == 26) || (n == 34) || (n == 42);
            if (tog)     exp_s   = ~exp_s;
            if (n == 18) exp_cnt = exp_cnt + 2'd1;
            chk_model("auto_mode", n, tog);
        end

        // Reset during PRESS_CHK: everything clears, and no press follows.
        for (int n = 1; n <= 15; n++) begin
            rst_n = (n != 5);
            btn_i = (n <= 5);
            tick();
            if (n == 5) begin exp_a = 1'b0; exp_b = 1'b0; exp_s = 1'b0; exp_cnt = 2'd0; end
            if (n == 7) begin exp_a = 1'b1; exp_b = 1'b1; end
            chk_model("reset_mid_debounce", n, 1'b0);
        end

        // Four clean presses from zero: the counter steps 1,2,3,0 (wrap).
        for (int p = 0; p < 4; p++) begin
            for (int n = 1; n <= 20; n++) begin
                btn_i = (n <= 10);
                tick();
                tog = (n == 7);
                if (tog) begin exp_s = ~exp_s; exp_cnt = exp_cnt + 2'd1; end
                chk_model("wrap_press", p * 20 + n, tog);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Input-conditioning and select-generation stage that sits directly upstream of the 2:1 mux.
- Synchronizes raw board switches and a pushbutton, and debounces the button.
- Drives the mux data inputs (a_o, b_o) and the select (s_o).
- Select toggles on each debounced button press (manual mode) or periodically (auto mode); a wrapping press counter is exported for display/debug.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high/low samples required to accept a press/release; must be >= 2.
- AUTO_PERIOD, 8, clock cycles between select toggles in auto mode; must be >= 2.
- CNT_W, 8, width of the press counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- btn_i  input  1  raw pushbutton, asynchronous, may bounce.
- sw_a_i  input  1  raw switch for mux data input a, asynchronous.
- sw_b_i  input  1  raw switch for mux data input b, asynchronous.
- auto_en_i  input  1  raw mode switch, asynchronous; 1 = auto toggle, 0 = manual.
- a_o  output  1  synchronized sw_a_i, to mux input a.
- b_o  output  1  synchronized sw_b_i, to mux input b.
- s_o  output  1  mux select.
- s_toggle_o  output  1  one-cycle pulse, high in the cycle s_o takes its new value.
- press_cnt_o  output  CNT_W  count of accepted button presses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All sync flops, counters and outputs go to 0; FSM goes to IDLE.
  - Reset overrides every other event in that cycle; a debounce in progress is abandoned.
- Synchronizers:
  - Two-flop sync on btn_i, sw_a_i, sw_b_i and auto_en_i; second-stage outputs are btn_s, a_s, b_s, auto_s.
  - a_o = a_s, b_o = b_s, driven directly from the sync flops: 2-edge latency, no further filtering.
- Debounce FSM (8-bit or wider counter cnt), states IDLE, PRESS_CHK, PRESSED, REL_CHK:
  - IDLE: btn_s=1 -> PRESS_CHK, cnt<=0.
  - PRESS_CHK:
    - btn_s=0 -> IDLE.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED and raise internal press event.
    - Otherwise cnt<=cnt+1.
  - PRESSED: btn_s=0 -> REL_CHK, cnt<=0. Holding the button never generates further events.
  - REL_CHK:
    - btn_s=1 -> PRESSED (bounce during release, no new event).
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt<=cnt+1.
- Press event latency: with btn_i held high from edge 1, the event fires at edge DEBOUNCE_CYCLES+3, and s_o/press_cnt_o update at that edge.
- Press event (any mode): press_cnt_o <= press_cnt_o+1, wrapping from 2^CNT_W-1 to 0.
- Manual mode (auto_s=0): a press event toggles s_o at the same edge.
- Auto mode (auto_s=1):
  - Period counter pcnt counts 0..AUTO_PERIOD-1; at pcnt==AUTO_PERIOD-1, s_o toggles and pcnt<=0.
  - Button events still increment press_cnt_o but do not toggle s_o, so there is never a double toggle.
- Mode switch:
  - auto_s 0->1: pcnt starts from 0, so the first auto toggle comes AUTO_PERIOD edges after auto_s is first sampled high.
  - auto_s 1->0: pcnt is cleared and s_o holds its current value.
- s_toggle_o: registered, 1 for exactly the cycle following each edge at which s_o changed, otherwise 0.
- No other outputs change except as described above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all inputs at 1 -> a_o=b_o=s_o=s_toggle_o=0 and press_cnt_o=0; a_o=b_o=1 exactly 2 edges after release.
- Clean press, manual mode, DEBOUNCE_CYCLES=4: btn_i high from edge 1 for 20 cycles, then low for 20 -> s_o 0->1 at edge 7, one s_toggle_o pulse, press_cnt_o=1, no further toggles.
- Bounce rejection: btn_i pulses high for 3 cycles, low 2, high 3, low 10 -> s_o stays 0 and press_cnt_o stays 0.
- Release bounce: after an accepted press, btn_i drops for 2 cycles, rises for 2, then stays low -> exactly one press counted.
- Auto mode, AUTO_PERIOD=8: auto_en_i=1 for 40 cycles, with one clean press in between -> s_o toggles every 8 edges, starting 8 edges after auto_s rises; the press raises press_cnt_o to 1 with no extra toggle; after auto_en_i drops, s_o holds.
- Wrap and reset mid-debounce, CNT_W=2: 4 clean presses -> press_cnt_o sequence 1,2,3,0; rst_n=0 during PRESS_CHK -> state IDLE, no toggle, counters 0.
